// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin front end for a single-port on-chip RAM with one-cycle read latency.
// After reset an optional clear engine zero-fills the RAM before either master is served.
module onchip_mem_arbiter #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 32000,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                init_done
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                init_done_q, init_done_d;
    logic                rr_last_q, rr_last_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_own_q, rd_own_d;
    logic                req0, req1, gnt0, gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rr_last_q   <= 1'b1;
            rd_vld_q    <= 1'b0;
            rd_own_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rr_last_q   <= rr_last_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
        end
    end

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        init_done_d    = init_done_q;
        rr_last_d      = rr_last_q;
        rd_vld_d       = 1'b0;
        rd_own_d       = rd_own_q;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = clr_cnt_q;
                mem_byteenable = {BE_W{1'b1}};
                clr_cnt_d      = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    clr_cnt_d   = '0;
                end
            end
            default: begin
                init_done_d = 1'b1;
                // rr_last names the master served most recently; the other one wins a tie
                gnt0 = req0 & (~req1 | rr_last_q);
                gnt1 = req1 & (~req0 | ~rr_last_q);
                if (gnt0) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m0_write;
                    mem_address    = m0_address;
                    mem_byteenable = m0_byteenable;
                    mem_writedata  = m0_writedata;
                end else if (gnt1) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m1_write;
                    mem_address    = m1_address;
                    mem_byteenable = m1_byteenable;
                    mem_writedata  = m1_writedata;
                end
                if (gnt0 | gnt1) begin
                    rr_last_d = gnt1;
                    rd_own_d  = gnt1;
                    // read+write together is treated as a write with no response
                    rd_vld_d  = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
                end
            end
        endcase
    end

    assign mem_clken        = 1'b1;
    assign m0_waitrequest   = ~(reset_n & gnt0);
    assign m1_waitrequest   = ~(reset_n & gnt1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_vld_q & ~rd_own_q;
    assign m1_readdatavalid = rd_vld_q & rd_own_q;
    assign init_done        = init_done_q | ((CLEAR_ON_RESET == 0) & reset_n);

endmodule
